ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_seq_pkg.sv | 16 +
 rtl/ram_seq_ctrl_if.sv | 49 ++++
 rtl/ram_seq_chk.sv | 33 +++
 rtl/ram_seq_ctrl.sv | 100 ++++++++++
 tb/tb_ram_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM sequencing controller: default widths and FSM states.
package ram_seq_pkg;

  localparam int DEF_OW = 4;
  localparam int DEF_DW = DEF_OW + 1;
  localparam int DEF_AW = 2 * DEF_OW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Request / RAM / response bundle of ram_seq_ctrl. ERR and ERR_CNT exist only
// when RAM_SEQ_CHECK_EN is defined.
interface ram_seq_ctrl_if import ram_seq_pkg::*; #(
  parameter int OW = DEF_OW,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WR;
  logic [OW-1:0] REQ_A;
  logic [OW-1:0] REQ_B;
  logic          RAM_CS;
  logic          RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DIN;
  logic [DW-1:0] RAM_DOUT;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_DATA;
  logic [AW-1:0] RSP_ADDR;
  logic          BUSY;
`ifdef RAM_SEQ_CHECK_EN
  logic          ERR;
  logic [7:0]    ERR_CNT;
`endif

  // Controller side.
  modport slave (
    input  REQ_VALID, REQ_WR, REQ_A, REQ_B, RAM_DOUT, RSP_READY,
    output REQ_READY, RAM_CS, RAM_WE, RAM_ADDR, RAM_DIN,
    output RSP_VALID, RSP_DATA, RSP_ADDR, BUSY
`ifdef RAM_SEQ_CHECK_EN
    , output ERR, ERR_CNT
`endif
  );

  // Requester, RAM and response-consumer side.
  modport master (
    output REQ_VALID, REQ_WR, REQ_A, REQ_B, RAM_DOUT, RSP_READY,
    input  REQ_READY, RAM_CS, RAM_WE, RAM_ADDR, RAM_DIN,
    input  RSP_VALID, RSP_DATA, RSP_ADDR, BUSY
`ifdef RAM_SEQ_CHECK_EN
    , input ERR, ERR_CNT
`endif
  );

endinterface

// File: rtl/ram_seq_chk.sv
// Read-data checker: a RAM word is expected to hold the sum of the two operand
// halves of its address. Pulses err on mismatch and keeps a saturating count.
module ram_seq_chk import ram_seq_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int OW = DEF_OW,
  parameter int DW = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          sample,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] addr,
  output logic          err,
  output logic [7:0]    err_cnt
);

  logic [DW-1:0] expected;
  logic          mismatch;

  assign expected = DW'(addr[AW-1:OW]) + DW'(addr[OW-1:0]);
  assign mismatch = sample && (data != expected);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= mismatch;
      if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequences write-sum / read-back requests onto a 1-cycle-latency synchronous RAM.
// Optional read-data checker (ERR, ERR_CNT) is built when RAM_SEQ_CHECK_EN is defined.
module ram_seq_ctrl import ram_seq_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int OW = DEF_OW,
  parameter int DW = DEF_DW
) (
  input logic           CLK,
  input logic           RST_N,
  ram_seq_ctrl_if.slave bus
);

  state_t        state_q, state_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  // Strobes are computed one state ahead so CS/WE/DIN come straight from flops.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          addr_d = {bus.REQ_A, bus.REQ_B};
          cs_d   = 1'b1;
          if (bus.REQ_WR) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            din_d   = DW'(bus.REQ_A) + DW'(bus.REQ_B);
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        rsp_data_d = bus.RAM_DOUT;
        state_d    = ST_RESP;
      end
      ST_RESP:  if (bus.RSP_READY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      state_q    <= state_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // The latched address doubles as the response address; it only moves on accept.
  assign bus.REQ_READY = (state_q == ST_IDLE);
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.RSP_VALID = (state_q == ST_RESP);
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ADDR  = addr_q;
  assign bus.RAM_CS    = cs_q;
  assign bus.RAM_WE    = we_q;
  assign bus.RAM_ADDR  = addr_q;
  assign bus.RAM_DIN   = din_q;

`ifdef RAM_SEQ_CHECK_EN
  ram_seq_chk #(
    .AW(AW),
    .OW(OW),
    .DW(DW)
  ) u_chk (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .sample  (state_q == ST_WAIT),
    .data    (bus.RAM_DOUT),
    .addr    (addr_q),
    .err     (bus.ERR),
    .err_cnt (bus.ERR_CNT)
  );
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Self-checking bench for ram_seq_ctrl: table of write/read vectors, response
// scoreboard, and directed backpressure / reset / corrupt-RAM sequences.
module tb_ram_seq_ctrl;
  import ram_seq_pkg::*;

  localparam int OW = DEF_OW;
  localparam int DW = DEF_DW;
  localparam int AW = DEF_AW;

  typedef struct {
    bit            wr;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [DW-1:0] data;   // DIN for writes, RSP_DATA for reads
    logic [AW-1:0] addr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } rsp_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  ram_seq_ctrl_if #(.OW(OW), .DW(DW), .AW(AW)) bus ();

  ram_seq_ctrl #(.AW(AW), .OW(OW), .DW(DW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // 256x5 synchronous RAM, 1-cycle read; init fills mem[i]=i, corrupt zeroes 0x37.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_dout;
  logic          ram_init;
  logic          ram_corrupt;

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
      ram_dout <= '0;
    end else if (ram_corrupt) begin
      mem[8'h37] <= '0;
    end else if (bus.RAM_CS) begin
      if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DIN;
      else            ram_dout <= mem[bus.RAM_ADDR];
    end
  end
  assign bus.RAM_DOUT = ram_dout;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cs_cnt = 0;
  int   rsp_seen = 0;
  rsp_t sb_q[$];
  rsp_t exp_r;

  logic [DW-1:0] last_din;
  logic [7:0]    exp_err_cnt;
  bit            prev_wr;
  int            prev_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Response monitor: pops the scoreboard on every completed response handshake.
  always @(negedge CLK) begin
    if (bus.RAM_CS) cs_cnt++;
    if (RST_N && bus.RSP_VALID) begin
      rsp_seen++;
      if (bus.RSP_READY) begin
        check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_r = sb_q.pop_front();
          check("rsp_data_addr", 32'({bus.RSP_DATA, bus.RSP_ADDR}), 32'({exp_r.data, exp_r.addr}));
        end
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns just after the accept edge.
  task automatic issue(input bit wr, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       output int acc);
    bit ok = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WR    = wr;
    bus.REQ_A     = a;
    bus.REQ_B     = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.REQ_READY;
    end
    check("accepted", 32'(ok), 32'd1);
    @(posedge CLK);
    #1;
    acc = cyc;
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   acc;
    logic e;
    issue(v.wr, v.a, v.b, acc);
    if (v.wr) begin
      if (prev_wr) check("wr_rate", 32'(acc - prev_acc), 32'd2);
      @(negedge CLK);
      check("wr_strobe",
            32'({bus.RAM_CS, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DIN, bus.REQ_READY, bus.BUSY}),
            32'({1'b1, 1'b1, v.addr, v.data, 1'b0, 1'b1}));
      last_din = v.data;
      @(posedge CLK);
      #1;
      check("wr_done", 32'({bus.REQ_READY, bus.RAM_CS, bus.RAM_WE, bus.RAM_DIN}),
            32'({1'b1, 1'b0, 1'b0, last_din}));
    end else begin
      sb_q.push_back('{v.data, v.addr});
      @(negedge CLK);
      check("rd_strobe",
            32'({bus.RAM_CS, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DIN, bus.REQ_READY}),
            32'({1'b1, 1'b0, v.addr, last_din, 1'b0}));
      @(negedge CLK);
      check("rd_wait", 32'({bus.RAM_CS, bus.RSP_VALID}), 32'd0);
      @(negedge CLK);
      check("rd_latency", 32'(bus.RSP_VALID), 32'd1);
      e = (v.data != DW'(v.a) + DW'(v.b));
      if (e && exp_err_cnt != 8'hFF) exp_err_cnt++;
`ifdef RAM_SEQ_CHECK_EN
      check("chk_err", 32'({bus.ERR, bus.ERR_CNT}), 32'({e, exp_err_cnt}));
`endif
      @(posedge CLK);
      #1;
      check("rd_done", 32'({bus.REQ_READY, bus.BUSY, bus.RSP_VALID}), 32'b100);
`ifdef RAM_SEQ_CHECK_EN
      check("chk_pulse_end", 32'(bus.ERR), 32'd0);
`endif
    end
    prev_wr  = v.wr;
    prev_acc = acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    vec_t cv;
    int   acc, c0, r0;

    vecs[0] = '{1'b1, 4'd2,  4'd3,  5'd5,  8'h23};
    vecs[1] = '{1'b1, 4'd15, 4'd15, 5'd30, 8'hFF};
    vecs[2] = '{1'b1, 4'd9,  4'd4,  5'd13, 8'h94};
    vecs[3] = '{1'b0, 4'd2,  4'd3,  5'd5,  8'h23};
    vecs[4] = '{1'b0, 4'd15, 4'd15, 5'd30, 8'hFF};
    vecs[5] = '{1'b1, 4'd0,  4'd0,  5'd0,  8'h00};
    vecs[6] = '{1'b0, 4'd9,  4'd4,  5'd13, 8'h94};
    vecs[7] = '{1'b0, 4'd0,  4'd0,  5'd0,  8'h00};
    vecs[8] = '{1'b0, 4'd1,  4'd1,  5'd17, 8'h11};  // never written: init pattern
    vecs[9] = '{1'b1, 4'd3,  4'd7,  5'd10, 8'h37};

    RST_N         = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WR    = 1'b0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b1;
    ram_init      = 1'b1;
    ram_corrupt   = 1'b0;
    last_din      = '0;
    exp_err_cnt   = '0;
    prev_wr       = 1'b0;
    prev_acc      = 0;

    repeat (2) @(posedge CLK);
    #1;
    ram_init = 1'b0;
    check("rst_vals",
          32'({bus.REQ_READY, bus.RAM_CS, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DIN,
               bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ADDR, bus.BUSY}),
          32'({1'b1, 30'd0}));
`ifdef RAM_SEQ_CHECK_EN
    check("rst_err", 32'({bus.ERR, bus.ERR_CNT}), 32'd0);
`endif

    // Idle after reset: no strobes for 10 cycles.
    RST_N = 1'b1;
    c0 = cs_cnt;
    repeat (10) @(posedge CLK);
    #1;
    check("idle_no_cs", 32'(cs_cnt - c0), 32'd0);
    check("idle_ready", 32'({bus.REQ_READY, bus.BUSY, bus.RSP_VALID}), 32'b100);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Response backpressure: hold RSP_READY low for 5 response cycles.
    prev_wr = 1'b0;
    bus.RSP_READY = 1'b0;
    issue(1'b0, 4'd15, 4'd15, acc);
    sb_q.push_back('{5'd30, 8'hFF});
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_hold", 32'({bus.RSP_VALID, bus.REQ_READY, bus.RSP_DATA, bus.RSP_ADDR}),
            32'({1'b1, 1'b0, 5'd30, 8'hFF}));
    end
    @(posedge CLK);
    #1;
    bus.RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_release", 32'({bus.REQ_READY, bus.BUSY, bus.RSP_VALID}), 32'b100);

    // Reset while the read strobe is out.
    issue(1'b0, 4'd2, 4'd3, acc);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_in_read", 32'({bus.RAM_CS, bus.BUSY, bus.REQ_READY}), 32'b001);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    last_din    = '0;
    exp_err_cnt = '0;

    // Reset during WAIT: response is discarded.
    issue(1'b0, 4'd2, 4'd3, acc);
    @(posedge CLK);
    #2;
    check("wait_state", 32'({bus.RAM_CS, bus.RSP_VALID, bus.BUSY}), 32'b001);
    RST_N = 1'b0;
    #1;
    check("rst_in_wait",
          32'({bus.RSP_VALID, bus.RAM_CS, bus.BUSY, bus.REQ_READY, bus.RSP_DATA, bus.RSP_ADDR}),
          32'({4'b0001, 13'd0}));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    c0 = cs_cnt;
    r0 = rsp_seen;
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_cs", 32'(cs_cnt - c0), 32'd0);
    check("post_rst_rsp", 32'(rsp_seen - r0), 32'd0);

    // Corrupted RAM word: readback returns what the RAM shows.
    ram_corrupt = 1'b1;
    @(posedge CLK);
    #1;
    ram_corrupt = 1'b0;
    prev_wr = 1'b0;
    cv = '{1'b0, 4'd3, 4'd7, 5'd0, 8'h37};
    run_vec(cv);
`ifdef RAM_SEQ_CHECK_EN
    check("chk_cnt_one", 32'(bus.ERR_CNT), 32'd1);
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
